// File: rtl/half_adder_pkg.sv
// Shared constants, lane result type and config helper for the half_adder slice.
package half_adder_pkg;

  localparam int HA_MAX_WIDTH = 64;
  localparam int HA_DEF_CNT_W = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_lane_t;

  function automatic bit ha_width_ok(input int width);
    return (width >= 1) && (width <= HA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/half_adder_if.sv
// Bus bundle for half_adder: qualified input beat plus registered result.
// carry_count exists only when HALF_ADDER_STATS_EN is defined.
interface half_adder_if
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = HA_DEF_CNT_W
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] carry_count;

  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry, carry_count
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry, carry_count
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, sum, carry
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, carry
  );
`endif

  if (!ha_width_ok(WIDTH) || (CNT_W < 1)) begin : g_bad_cfg
    $error("half_adder_if: unsupported WIDTH/CNT_W");
  end

endinterface

// File: rtl/half_adder_lane.sv
// Combinational 1-bit half-adder cell; zero latency, no state.
module half_adder_lane
  import half_adder_pkg::*;
(
  input  logic     a_i,
  input  logic     b_i,
  output ha_lane_t res_o
);

  always_comb begin
    res_o.sum   = a_i ^ b_i;
    res_o.carry = a_i & b_i;
  end

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder: 1-cycle latency, one result per cycle, no backpressure.
// HALF_ADDER_STATS_EN adds a saturating count of accepted beats that produced any carry.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = HA_DEF_CNT_W
)(
  input  logic         clk,
  input  logic         rst_n,
  half_adder_if.slave  bus
);

  if (!ha_width_ok(WIDTH) || (CNT_W < 1)) begin : g_bad_cfg
    $error("half_adder: unsupported WIDTH/CNT_W");
  end

  ha_lane_t         lane_res [WIDTH];
  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_lane u_lane (
      .a_i   (bus.a[i]),
      .b_i   (bus.b[i]),
      .res_o (lane_res[i])
    );
    assign lane_sum[i]   = lane_res[i].sum;
    assign lane_carry[i] = lane_res[i].carry;
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             valid_q, valid_d;

  // Results only move on accepted beats, so idle-cycle junk on a/b never reaches the outputs.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d   = lane_sum;
      carry_d = lane_carry;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && (|lane_carry) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.carry_count = cnt_q;
`endif

  a_sum_carry_excl: assert property (@(posedge clk) disable iff (!rst_n)
    (sum_q & carry_q) == '0);

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: a 1-lane (CNT_W=2) and an 8-lane instance against an arithmetic lane model.
module tb_half_adder;

  localparam int CNT1 = 2;
  localparam int CNT8 = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  half_adder_if #(.WIDTH(1), .CNT_W(CNT1)) ifc1 ();
  half_adder_if #(.WIDTH(8), .CNT_W(CNT8)) ifc8 ();

  half_adder #(.WIDTH(1), .CNT_W(CNT1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
  half_adder #(.WIDTH(8), .CNT_W(CNT8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));

  int n_checks = 0;
  int n_pass   = 0;

  logic [0:0] e1_sum, e1_carry;
  logic       e1_vld;
  int         e1_cnt;
  logic [7:0] e8_sum, e8_carry;
  logic       e8_vld;
  int         e8_cnt;

  // Each lane adds two bits: sum is the low bit of the total, carry the high bit.
  function automatic void ha_ref(input logic [7:0] a, input logic [7:0] b, input int w,
                                 output logic [7:0] s, output logic [7:0] c);
    s = '0;
    c = '0;
    for (int i = 0; i < w; i++) begin
      int t;
      t    = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
  endfunction

  task automatic model_update();
    logic [7:0] s, c;
    if (!rst_n) begin
      e1_sum = '0; e1_carry = '0; e1_vld = 1'b0; e1_cnt = 0;
      e8_sum = '0; e8_carry = '0; e8_vld = 1'b0; e8_cnt = 0;
    end else begin
      e1_vld = ifc1.in_valid;
      if (ifc1.in_valid) begin
        ha_ref({7'b0, ifc1.a}, {7'b0, ifc1.b}, 1, s, c);
        e1_sum = s[0:0];
        e1_carry = c[0:0];
        if (c != 0 && e1_cnt < (1 << CNT1) - 1) e1_cnt++;
      end
      e8_vld = ifc8.in_valid;
      if (ifc8.in_valid) begin
        ha_ref(ifc8.a, ifc8.b, 8, s, c);
        e8_sum = s;
        e8_carry = c;
        if (c != 0 && e8_cnt < (1 << CNT8) - 1) e8_cnt++;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc1.in_valid = 1'b0; ifc1.a = '0; ifc1.b = '0;
    ifc8.in_valid = 1'b0; ifc8.a = '0; ifc8.b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc1.in_valid = 1'b1; ifc1.a = 1'b1; ifc1.b = 1'b1;
    ifc8.in_valid = 1'b1; ifc8.a = 8'hFF; ifc8.b = 8'hFF;
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 2) begin
        rst_n = 1'b1;
        idle_inputs();
      end
      tick();
      n_checks++;
      if ({ifc1.out_valid, ifc1.sum, ifc1.carry} !== 3'b000)
        $display("FAIL reset_w1 cyc%0d: got %b want 000", cyc, {ifc1.out_valid, ifc1.sum, ifc1.carry});
      else n_pass++;
      n_checks++;
      if ({ifc8.out_valid, ifc8.sum, ifc8.carry} !== 17'h0)
        $display("FAIL reset_w8 cyc%0d: got %h want 0", cyc, {ifc8.out_valid, ifc8.sum, ifc8.carry});
      else n_pass++;
`ifdef HALF_ADDER_STATS_EN
      n_checks++;
      if (ifc1.carry_count !== '0 || ifc8.carry_count !== '0)
        $display("FAIL reset_cnt cyc%0d: got %0d/%0d want 0/0", cyc, ifc1.carry_count, ifc8.carry_count);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] exp_sc [4];
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      ifc1.in_valid = 1'b1;
      ifc1.a = ab[1];
      ifc1.b = ab[0];
      tick();
      n_checks++;
      if ({ifc1.out_valid, ifc1.sum, ifc1.carry} !== {1'b1, exp_sc[i]})
        $display("FAIL truth_ab%b: got vld/s/c %b want %b", ab,
                 {ifc1.out_valid, ifc1.sum, ifc1.carry}, {1'b1, exp_sc[i]});
      else n_pass++;
    end
  endtask

  task automatic test_hold_idle();
    idle_inputs();
    ifc1.in_valid = 1'b1; ifc1.a = 1'b1; ifc1.b = 1'b0;
    tick();
    n_checks++;
    if ({ifc1.out_valid, ifc1.sum, ifc1.carry} !== 3'b110)
      $display("FAIL hold_capture: got %b want 110", {ifc1.out_valid, ifc1.sum, ifc1.carry});
    else n_pass++;
    ifc1.in_valid = 1'b0; ifc1.a = 1'b1; ifc1.b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({ifc1.out_valid, ifc1.sum, ifc1.carry} !== 3'b010)
        $display("FAIL hold_idle%0d: got %b want 010", k, {ifc1.out_valid, ifc1.sum, ifc1.carry});
      else n_pass++;
    end
  endtask

  task automatic test_multilane();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vs [3];
    logic [7:0] vc [3];
    va = '{8'hF0, 8'hFF, 8'h0A};
    vb = '{8'hCC, 8'h01, 8'h06};
    vs = '{8'h3C, 8'hFE, 8'h0C};
    vc = '{8'hC0, 8'h01, 8'h02};
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ifc8.in_valid = 1'b1; ifc8.a = va[i]; ifc8.b = vb[i];
      tick();
      n_checks++;
      if ({ifc8.out_valid, ifc8.sum, ifc8.carry} !== {1'b1, vs[i], vc[i]})
        $display("FAIL lanes_%h_%h: got vld=%b s=%h c=%h want 1 %h %h", va[i], vb[i],
                 ifc8.out_valid, ifc8.sum, ifc8.carry, vs[i], vc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    ifc1.in_valid = 1'b1; ifc1.a = 1'b1; ifc1.b = 1'b1;
    ifc8.in_valid = 1'b1; ifc8.a = 8'hFF; ifc8.b = 8'hFF;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({ifc1.out_valid, ifc1.sum, ifc1.carry, ifc8.out_valid, ifc8.sum, ifc8.carry} !== 20'h0)
      $display("FAIL reset_mid: got w1=%b w8=%h want 0", {ifc1.out_valid, ifc1.sum, ifc1.carry},
               {ifc8.out_valid, ifc8.sum, ifc8.carry});
    else n_pass++;
    rst_n = 1'b1;
    ifc1.a = 1'b1; ifc1.b = 1'b0;
    ifc8.a = 8'h0A; ifc8.b = 8'h06;
    tick();
    n_checks++;
    if ({ifc1.out_valid, ifc1.sum, ifc1.carry} !== 3'b110 ||
        {ifc8.out_valid, ifc8.sum, ifc8.carry} !== {1'b1, 8'h0C, 8'h02})
      $display("FAIL reset_mid_after: got w1=%b w8=%h want 110 / %h", {ifc1.out_valid, ifc1.sum, ifc1.carry},
               {ifc8.out_valid, ifc8.sum, ifc8.carry}, {1'b1, 8'h0C, 8'h02});
    else n_pass++;
  endtask

`ifdef HALF_ADDER_STATS_EN
  task automatic test_stats();
    logic [2:0] seq [8];
    int         want [8];
    seq  = '{3'b111, 3'b111, 3'b101, 3'b011, 3'b111, 3'b100, 3'b111, 3'b111};
    want = '{1, 2, 2, 2, 3, 3, 3, 3};
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifc1.in_valid = seq[i][2];
      ifc1.a = seq[i][1];
      ifc1.b = seq[i][0];
      tick();
      n_checks++;
      if (int'(ifc1.carry_count) != want[i])
        $display("FAIL stats_step%0d: got %0d want %0d", i, ifc1.carry_count, want[i]);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 300; cyc++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      ifc1.in_valid = 1'($urandom);
      ifc1.a = 1'($urandom);
      ifc1.b = 1'($urandom);
      ifc8.in_valid = 1'($urandom);
      ifc8.a = 8'($urandom);
      ifc8.b = 8'($urandom);
      tick();
      n_checks++;
      if ({ifc1.out_valid, ifc1.sum, ifc1.carry} !== {e1_vld, e1_sum, e1_carry})
        $display("FAIL rand_w1 cyc%0d: got %b want %b", cyc, {ifc1.out_valid, ifc1.sum, ifc1.carry},
                 {e1_vld, e1_sum, e1_carry});
      else n_pass++;
      n_checks++;
      if ({ifc8.out_valid, ifc8.sum, ifc8.carry} !== {e8_vld, e8_sum, e8_carry})
        $display("FAIL rand_w8 cyc%0d: got vld=%b s=%h c=%h want %b %h %h", cyc, ifc8.out_valid,
                 ifc8.sum, ifc8.carry, e8_vld, e8_sum, e8_carry);
      else n_pass++;
      n_checks++;
      if ((ifc8.sum & ifc8.carry) !== 8'h00 || (ifc1.sum & ifc1.carry) !== 1'b0)
        $display("FAIL rand_excl cyc%0d: got w8 s&c=%h w1 s&c=%b want 0", cyc,
                 ifc8.sum & ifc8.carry, ifc1.sum & ifc1.carry);
      else n_pass++;
`ifdef HALF_ADDER_STATS_EN
      n_checks++;
      if (int'(ifc1.carry_count) != e1_cnt || int'(ifc8.carry_count) != e8_cnt)
        $display("FAIL rand_cnt cyc%0d: got %0d/%0d want %0d/%0d", cyc, ifc1.carry_count,
                 ifc8.carry_count, e1_cnt, e8_cnt);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_exhaustive_w1();
    test_hold_idle();
    test_multilane();
    test_reset_mid();
`ifdef HALF_ADDER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered, lane-parallel half adder: WIDTH independent 1-bit lanes, each computing sum = a XOR b and carry = a AND b.
- Basic arithmetic leaf cell for adder/counter datapaths.
- Inputs are sampled on a qualifying clock edge; results appear one cycle later with a valid flag.
- With WIDTH=1 it is the classic 1-bit half adder with a single output register stage.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1..64.
- CNT_W, 16, width of the optional carry-event counter; only used when HALF_ADDER_STATS_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  WIDTH  addend bits, lane i = a[i].
- b  input  WIDTH  addend bits, lane i = b[i].
- out_valid  output  1  sum and carry hold a fresh result this cycle.
- sum  output  WIDTH  per-lane a XOR b, registered.
- carry  output  WIDTH  per-lane a AND b, registered.
- carry_count  output  CNT_W  optional; present only with HALF_ADDER_STATS_EN.

Behaviour:
- Reset: rst_n low at a rising edge forces sum=0, carry=0, out_valid=0 (and carry_count=0 if present). Reset takes priority over in_valid.
- Reset mid-operation discards any result that would have been registered that cycle.
- Capture: on a rising edge with rst_n=1 and in_valid=1:
  - sum <= a ^ b
  - carry <= a & b
  - out_valid <= 1
- Idle: on a rising edge with rst_n=1 and in_valid=0, out_valid <= 0. sum and carry hold their previous values; no toggling on idle cycles.
- Latency is exactly 1 cycle from the accepting edge to valid outputs. Back-to-back in_valid gives one result per cycle; no stall and no backpressure.
- Lanes are fully independent. No carry propagates between lanes.
- Per-lane truth table:
  - 00 -> sum 0, carry 0
  - 01 -> sum 1, carry 0
  - 10 -> sum 1, carry 0
  - 11 -> sum 0, carry 1
- Invariant: for every lane, carry & sum == 0 at all times.
- X on a or b while in_valid=0 must not propagate into outputs.

Optional Feature:
- Macro HALF_ADDER_STATS_EN.
- Defined:
  - carry_count port exists.
  - Increments by 1 on each accepted cycle (in_valid=1, rst_n=1) in which any lane of a & b is 1.
  - Saturates at all-ones; never wraps.
  - Updates in the same edge as sum and carry; reset to 0.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package half_adder_pkg:
  - constant HA_MAX_WIDTH = 64
  - constant HA_DEF_CNT_W = 16
  - typedef ha_lane_t, a packed struct {sum, carry}, used by lane outputs
- Sub-module half_adder_lane: purely combinational 1-bit cell (a, b -> sum, carry), instantiated WIDTH times via generate.
- Top module holds the registers, valid tracking, and the optional counter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=1, b=1 -> sum=0, carry=0, out_valid=0 throughout and on the first edge after release.
- Exhaustive WIDTH=1: apply ab=00, 01, 10, 11 on consecutive cycles with in_valid=1 -> one cycle later sum/carry = 0/0, 1/0, 1/0, 0/1; out_valid=1 on each.
- Hold on idle: capture a=1, b=0, then in_valid=0 for 3 cycles with a=1, b=1 -> sum stays 1, carry stays 0, out_valid=0 after the first idle edge.
- Multi-lane WIDTH=8: a=8'hF0, b=8'hCC -> sum=8'h3C, carry=8'hC0; confirm no inter-lane carry.
- Reset mid-stream: in_valid=1 with a=1, b=1 while rst_n=0 on that edge -> outputs 0, out_valid=0; next accepted input is produced normally.
- STATS (macro defined, CNT_W=2): 5 accepted cycles each with a=b=1 -> carry_count reads 1, 2, 3, 3, 3; cycles with a&b=0 leave it unchanged.
